enemy_controller: RTL and testbench

//  Per-enemy state engine sitting directly upstream of the enemy sprite drawer.

---
 rtl/enemy_controller.sv | 160 ++++++++++++++++
 tb/tb_enemy_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/enemy_controller.sv
// enemy_controller: per-enemy state engine feeding the enemy sprite drawer.
// Spawns an enemy, moves it once per frame, applies bullet hits and retires it.
// Optional feature macro: ENEMY_HIT_COOLDOWN_EN (hit-immune frames after a non-killing hit).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   frame_tick          one-cycle pulse per frame (vblank start)
//   spawn, spawn_type,  spawn request with type (0..2, 3 ignored) and requested x_mid
//   spawn_x
//   hit                 one-cycle bullet-collision pulse
//   enemy_type, health, sprite attributes for the drawer
//   x_mid, y_mid
//   visible, alive      ACTIVE or DYING / ACTIVE only
//   killed, escaped     one-cycle event pulses
module enemy_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       spawn,
  input  logic [1:0] spawn_type,
  input  logic [9:0] spawn_x,
  input  logic       hit,
  output logic [1:0] enemy_type,
  output logic [3:0] health,
  output logic [9:0] x_mid,
  output logic [9:0] y_mid,
  output logic       visible,
  output logic       alive,
  output logic       killed,
  output logic       escaped
);
  localparam logic [9:0] Y_SPAWN      = 10'd8;
  localparam logic [9:0] Y_ESCAPE     = 10'd472;
  localparam logic [9:0] X_MIN        = 10'd8;
  localparam logic [9:0] X_MAX        = 10'd631;
  localparam logic [3:0] SPEED_T0     = 4'd1;
  localparam logic [3:0] SPEED_T1     = 4'd2;
  localparam logic [3:0] SPEED_T2     = 4'd1;
  localparam logic [3:0] DRIFT        = 4'd2;
  localparam logic [3:0] DEATH_FRAMES = 4'd8;

  typedef enum logic [1:0] {IDLE, ACTIVE, DYING} state_t;

  state_t     state, state_n;
  logic [1:0] type_n;
  logic [3:0] health_n, health_dec, dcnt, dcnt_n;
  logic [9:0] x_n, y_n;
  logic       left, left_n, killed_n, escaped_n, hit_ok;
  logic [3:0] speed;
  logic [10:0] y_next, x_r, x_l;

`ifdef ENEMY_HIT_COOLDOWN_EN
  localparam logic [3:0] COOLDOWN = 4'd4;
  logic [3:0] cool, cool_n;
  assign hit_ok = hit && cool == 4'd0;
`else
  assign hit_ok = hit;
`endif

  assign visible    = state != IDLE;
  assign alive      = state == ACTIVE;
  assign speed      = enemy_type == 2'd1 ? SPEED_T1 : enemy_type == 2'd2 ? SPEED_T2 : SPEED_T0;
  // 11-bit arithmetic so the escape and bound compares never see a wrapped value
  assign y_next     = {1'b0, y_mid} + {7'd0, speed};
  assign x_r        = {1'b0, x_mid} + {7'd0, DRIFT};
  assign x_l        = {1'b0, x_mid} - {7'd0, DRIFT};
  assign health_dec = health == 4'd0 ? 4'd0 : health - 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      enemy_type <= 2'd0;
      health     <= 4'd0;
      x_mid      <= 10'd0;
      y_mid      <= 10'd0;
      left       <= 1'b0;
      dcnt       <= 4'd0;
      killed     <= 1'b0;
      escaped    <= 1'b0;
`ifdef ENEMY_HIT_COOLDOWN_EN
      cool       <= 4'd0;
`endif
    end else begin
      state      <= state_n;
      enemy_type <= type_n;
      health     <= health_n;
      x_mid      <= x_n;
      y_mid      <= y_n;
      left       <= left_n;
      dcnt       <= dcnt_n;
      killed     <= killed_n;
      escaped    <= escaped_n;
`ifdef ENEMY_HIT_COOLDOWN_EN
      cool       <= cool_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    type_n    = enemy_type;
    health_n  = health;
    x_n       = x_mid;
    y_n       = y_mid;
    left_n    = left;
    dcnt_n    = dcnt;
    killed_n  = 1'b0;
    escaped_n = 1'b0;
`ifdef ENEMY_HIT_COOLDOWN_EN
    cool_n    = cool;
`endif
    case (state)
      IDLE: if (spawn && spawn_type != 2'd3) begin
        state_n  = ACTIVE;
        type_n   = spawn_type;
        health_n = spawn_type == 2'd0 ? 4'd1 : spawn_type == 2'd1 ? 4'd3 : 4'd4;
        y_n      = Y_SPAWN;
        x_n      = spawn_x < X_MIN ? X_MIN : spawn_x > X_MAX ? X_MAX : spawn_x;
        left_n   = 1'b0;
`ifdef ENEMY_HIT_COOLDOWN_EN
        cool_n   = 4'd0;
`endif
      end
      ACTIVE: begin
        if (hit_ok) health_n = health_dec;
`ifdef ENEMY_HIT_COOLDOWN_EN
        if (frame_tick && cool != 4'd0) cool_n = cool - 4'd1;
        if (hit_ok) cool_n = COOLDOWN;
`endif
        // a killing hit wins over this frame's movement and any escape
        if (hit_ok && health_dec == 4'd0) begin
          state_n  = DYING;
          killed_n = 1'b1;
          health_n = 4'd1;
          dcnt_n   = DEATH_FRAMES;
        end else if (frame_tick) begin
          if (y_next >= {1'b0, Y_ESCAPE}) begin
            state_n   = IDLE;
            escaped_n = 1'b1;
          end else begin
            y_n = y_next[9:0];
            if (enemy_type == 2'd2) begin
              if (!left) begin
                x_n    = x_r > {1'b0, X_MAX} ? X_MAX : x_r[9:0];
                left_n = x_r > {1'b0, X_MAX};
              end else begin
                x_n    = x_l < {1'b0, X_MIN} ? X_MIN : x_l[9:0];
                left_n = !(x_l < {1'b0, X_MIN});
              end
            end
          end
        end
      end
      DYING: if (frame_tick) begin
        dcnt_n = dcnt - 4'd1;
        if (dcnt == 4'd1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_enemy_controller.sv
// tb_enemy_controller: directed self-checking bench for enemy_controller.
module tb_enemy_controller;
  logic       clk = 0, rst_n = 0, frame_tick = 0, spawn = 0, hit = 0;
  logic [1:0] spawn_type = 0;
  logic [9:0] spawn_x = 0;
  logic [1:0] enemy_type;
  logic [3:0] health;
  logic [9:0] x_mid, y_mid;
  logic       visible, alive, killed, escaped;
  int checks = 0, failures = 0;

  enemy_controller dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .spawn(spawn),
    .spawn_type(spawn_type), .spawn_x(spawn_x), .hit(hit),
    .enemy_type(enemy_type), .health(health), .x_mid(x_mid), .y_mid(y_mid),
    .visible(visible), .alive(alive), .killed(killed), .escaped(escaped)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1; cyc();
      frame_tick = 0; cyc();
    end
  endtask

  task automatic do_reset();
    rst_n = 0; frame_tick = 0; spawn = 0; hit = 0; cyc();
    rst_n = 1; cyc();
  endtask

  task automatic do_spawn(input logic [1:0] t, input logic [9:0] x);
    spawn = 1; spawn_type = t; spawn_x = x; cyc();
    spawn = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; #1;
    checks++;
    if ({enemy_type, health, x_mid, y_mid, visible, alive, killed, escaped} !== 30'd0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {enemy_type, health, x_mid, y_mid, visible, alive, killed, escaped});
    end
    cyc(); rst_n = 1; cyc();
  endtask

  task automatic test_spawn();
    do_reset();
    do_spawn(2'd3, 10'd100); cyc();
    checks++;
    if (visible !== 1'b0) begin failures++; $display("FAIL spawn_type3_ignored visible=%b exp=0", visible); end
    do_spawn(2'd2, 10'd700);
    checks++;
    if ({visible, alive} !== 2'b11) begin failures++; $display("FAIL spawn_vis_alive got=%b exp=11", {visible, alive}); end
    checks++;
    if (health !== 4'd4) begin failures++; $display("FAIL spawn_health got=%0d exp=4", health); end
    checks++;
    if (x_mid !== 10'd631) begin failures++; $display("FAIL spawn_x_clamp_hi got=%0d exp=631", x_mid); end
    checks++;
    if (y_mid !== 10'd8 || enemy_type !== 2'd2) begin failures++; $display("FAIL spawn_y_type got=%0d/%0d exp=8/2", y_mid, enemy_type); end
    do_spawn(2'd0, 10'd100); cyc();
    checks++;
    if (enemy_type !== 2'd2 || x_mid !== 10'd631) begin failures++; $display("FAIL spawn_active_ignored got=%0d/%0d exp=2/631", enemy_type, x_mid); end
    do_reset();
    do_spawn(2'd0, 10'd3);
    checks++;
    if (x_mid !== 10'd8 || health !== 4'd1) begin failures++; $display("FAIL spawn_x_clamp_lo got=%0d/%0d exp=8/1", x_mid, health); end
  endtask

  task automatic test_drift();
    do_reset();
    do_spawn(2'd2, 10'd630); cyc();
    tick(1);
    checks++;
    if (x_mid !== 10'd631 || y_mid !== 10'd9) begin failures++; $display("FAIL drift_clamp got=%0d/%0d exp=631/9", x_mid, y_mid); end
    tick(1);
    checks++;
    if (x_mid !== 10'd629) begin failures++; $display("FAIL drift_flip got=%0d exp=629", x_mid); end
    tick(1);
    checks++;
    if (x_mid !== 10'd627 || y_mid !== 10'd11) begin failures++; $display("FAIL drift_left got=%0d/%0d exp=627/11", x_mid, y_mid); end
  endtask

  task automatic test_escape();
    int pulses;
    do_reset();
    do_spawn(2'd1, 10'd100); cyc();
    tick(230);
    checks++;
    if (y_mid !== 10'd468 || visible !== 1'b1) begin failures++; $display("FAIL escape_pre got=%0d/%b exp=468/1", y_mid, visible); end
    tick(1);
    checks++;
    if (y_mid !== 10'd470 || escaped !== 1'b0) begin failures++; $display("FAIL escape_not_yet got=%0d/%b exp=470/0", y_mid, escaped); end
    frame_tick = 1; cyc(); frame_tick = 0;
    checks++;
    if ({escaped, visible, alive, killed} !== 4'b1000) begin failures++; $display("FAIL escape_pulse got=%b exp=1000", {escaped, visible, alive, killed}); end
    checks++;
    if (x_mid !== 10'd100 || y_mid !== 10'd470) begin failures++; $display("FAIL escape_hold got=%0d/%0d exp=100/470", x_mid, y_mid); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin cyc(); pulses += int'(escaped); end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL escape_once extra=%0d exp=0", pulses); end
  endtask

  task automatic test_kill();
    do_reset();
    do_spawn(2'd1, 10'd200); cyc();
    hit = 1; cyc(); hit = 0; tick(4);
    checks++;
    if (health !== 4'd2) begin failures++; $display("FAIL kill_hit1 got=%0d exp=2", health); end
    hit = 1; cyc(); hit = 0; tick(4);
    checks++;
    if (health !== 4'd1 || alive !== 1'b1) begin failures++; $display("FAIL kill_hit2 got=%0d/%b exp=1/1", health, alive); end
    hit = 1; cyc(); hit = 0;
    checks++;
    if ({killed, escaped, visible, alive} !== 4'b1010 || health !== 4'd1) begin failures++; $display("FAIL kill_pulse got=%b h=%0d exp=1010 h=1", {killed, escaped, visible, alive}, health); end
    checks++;
    if (y_mid !== 10'd24) begin failures++; $display("FAIL kill_y got=%0d exp=24", y_mid); end
    hit = 1; cyc(); hit = 0;
    checks++;
    if (killed !== 1'b0 || health !== 4'd1) begin failures++; $display("FAIL dying_hit_ignored got=%b/%0d exp=0/1", killed, health); end
    tick(7);
    checks++;
    if (visible !== 1'b1 || y_mid !== 10'd24) begin failures++; $display("FAIL dying_7 got=%b/%0d exp=1/24", visible, y_mid); end
    tick(1);
    checks++;
    if ({visible, alive, killed} !== 3'b000) begin failures++; $display("FAIL dying_done got=%b exp=000", {visible, alive, killed}); end
  endtask

  task automatic test_precedence();
    do_reset();
    do_spawn(2'd0, 10'd300); cyc();
    tick(463);
    checks++;
    if (y_mid !== 10'd471) begin failures++; $display("FAIL prec_pre got=%0d exp=471", y_mid); end
    hit = 1; frame_tick = 1; cyc(); hit = 0; frame_tick = 0;
    checks++;
    if ({killed, escaped, visible, alive} !== 4'b1010) begin failures++; $display("FAIL prec_flags got=%b exp=1010", {killed, escaped, visible, alive}); end
    checks++;
    if (y_mid !== 10'd471) begin failures++; $display("FAIL prec_y got=%0d exp=471", y_mid); end
    cyc();
    checks++;
    if ({killed, escaped} !== 2'b00) begin failures++; $display("FAIL prec_after got=%b exp=00", {killed, escaped}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_spawn(2'd2, 10'd320); cyc();
`ifdef ENEMY_HIT_COOLDOWN_EN
    hit = 1; cyc(); hit = 0; tick(2);
    checks++;
    if (health !== 4'd3) begin failures++; $display("FAIL cool_first got=%0d exp=3", health); end
    hit = 1; cyc(); hit = 0; tick(2);
    checks++;
    if (health !== 4'd3) begin failures++; $display("FAIL cool_ignored got=%0d exp=3", health); end
    hit = 1; cyc(); hit = 0;
    checks++;
    if (health !== 4'd2) begin failures++; $display("FAIL cool_expired got=%0d exp=2", health); end
`else
    hit = 1; cyc();
    checks++;
    if (health !== 4'd3) begin failures++; $display("FAIL b2b_first got=%0d exp=3", health); end
    cyc(); hit = 0;
    checks++;
    if (health !== 4'd2) begin failures++; $display("FAIL b2b_second got=%0d exp=2", health); end
`endif
  endtask

  task automatic test_reset_dying();
    do_reset();
    do_spawn(2'd0, 10'd50); cyc();
    hit = 1; cyc(); hit = 0; cyc();
    checks++;
    if (visible !== 1'b1 || alive !== 1'b0) begin failures++; $display("FAIL rd_in_dying got=%b%b exp=10", visible, alive); end
    #2 rst_n = 0; #1;
    checks++;
    if ({enemy_type, health, x_mid, y_mid, visible, alive, killed, escaped} !== 30'd0) begin
      failures++; $display("FAIL rd_async got=%h exp=0", {enemy_type, health, x_mid, y_mid, visible, alive, killed, escaped});
    end
    cyc(); rst_n = 1; cyc(); cyc();
    checks++;
    if ({visible, killed, escaped} !== 3'b000) begin failures++; $display("FAIL rd_no_pulse got=%b exp=000", {visible, killed, escaped}); end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_drift();
    test_escape();
    test_kill();
    test_precedence();
    test_back_to_back();
    test_reset_dying();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
